// File: rtl/arb_pkg.sv
// Shared types for the round-robin mux arbiter.
package arb_pkg;

    // IDLE: arbitrating between requesters; LOCK: grant held until the last beat of a packet.
    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mux_bin_tree.sv
// Binary-select mux built as a radix-SPLIT tree; each level consumes one
// SPLIT-ary digit of bin, least significant digit at the leaves.
module mux_bin_tree #(
    parameter  type DAT_T          = logic [7:0],
    parameter  int  WIDTH          = 8,
    parameter  int  SPLIT          = 2,
    parameter  int  IMPLEMENTATION = 0,
    localparam int  WIDTH_LOG      = $clog2(WIDTH)
) (
    input  DAT_T                 in_dat [WIDTH],
    input  logic [WIDTH_LOG-1:0] bin,
    output DAT_T                 out_dat
);

    localparam int SPLIT_LOG = $clog2(SPLIT);
    localparam int LEVELS    = WIDTH_LOG / SPLIT_LOG;

    if (IMPLEMENTATION == 0) begin : g_tree
        for (genvar gi = 0; gi < LEVELS; gi++) begin : g_lvl
            localparam int N_IN  = WIDTH / (SPLIT ** gi);
            localparam int N_OUT = N_IN / SPLIT;

            DAT_T                 lvl_in  [N_IN];
            DAT_T                 lvl_out [N_OUT];
            logic [SPLIT_LOG-1:0] digit;

            if (gi == 0) begin : g_leaf
                assign lvl_in = in_dat;
            end else begin : g_inner
                assign lvl_in = g_lvl[gi-1].lvl_out;
            end

            assign digit = bin[gi*SPLIT_LOG +: SPLIT_LOG];

            for (genvar gj = 0; gj < N_OUT; gj++) begin : g_node
                assign lvl_out[gj] = lvl_in[gj*SPLIT + int'(digit)];
            end
        end

        assign out_dat = g_lvl[LEVELS-1].lvl_out[0];
    end else begin : g_flat
        assign out_dat = in_dat[bin];
    end

endmodule

// File: rtl/pri_rr_bin.sv
// Rotating priority encoder: returns the first requester after ptr (wrapping)
// as a binary index.
module pri_rr_bin #(
    parameter  int WIDTH          = 8,
    parameter  int IMPLEMENTATION = 0,
    localparam int WIDTH_LOG      = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     req,
    input  logic [WIDTH_LOG-1:0] ptr,
    output logic [WIDTH_LOG-1:0] bin,
    output logic                 vld
);

    localparam logic [WIDTH_LOG-1:0] PTR_ONE = 1;
    localparam logic [WIDTH_LOG:0]   SH_ONE  = 1;

    if (IMPLEMENTATION == 0) begin : g_scan
        logic [WIDTH_LOG-1:0] cand;

        // Scan ptr+WIDTH down to ptr+1 so the nearest candidate after ptr is written last.
        always_comb begin
            bin  = '0;
            vld  = 1'b0;
            cand = '0;
            for (int k = WIDTH; k >= 1; k--) begin
                cand = ptr + k[WIDTH_LOG-1:0];
                if (req[cand]) begin
                    bin = cand;
                    vld = 1'b1;
                end
            end
        end
    end else begin : g_rot
        logic [WIDTH-1:0]     rot;
        logic [WIDTH_LOG:0]   sh;
        logic [WIDTH_LOG-1:0] off;

        // Rotate the request vector so the slot after ptr sits at bit 0, then take the lowest set bit.
        always_comb begin
            sh  = {1'b0, ptr} + SH_ONE;
            rot = WIDTH'({req, req} >> sh);
            off = '0;
            for (int k = WIDTH - 1; k >= 0; k--) begin
                if (rot[k]) off = k[WIDTH_LOG-1:0];
            end
            bin = ptr + off + PTR_ONE;
            vld = |rot;
        end
    end

endmodule

// File: rtl/arb_rr_mux_bin.sv
// Round-robin arbiter sharing one mux tree among WIDTH valid/ready sources,
// with packet locking and a single registered output stage.
module arb_rr_mux_bin
    import arb_pkg::*;
#(
    parameter  type DAT_T          = logic [7:0],
    parameter  int  WIDTH          = 8,
    parameter  int  SPLIT          = 2,
    parameter  int  IMPLEMENTATION = 0,
    localparam int  WIDTH_LOG      = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     req_vld,
    input  logic [WIDTH-1:0]     req_lst,
    input  DAT_T                 req_dat [WIDTH],
    output logic [WIDTH-1:0]     req_rdy,
    output logic                 out_vld,
    output logic                 out_lst,
    output DAT_T                 out_dat,
    output logic [WIDTH_LOG-1:0] out_idx,
    input  logic                 out_rdy
);

    arb_state_t           state_q, state_d;
    logic [WIDTH_LOG-1:0] ptr_q, ptr_d;
    logic [WIDTH_LOG-1:0] lck_q, lck_d;
    logic [WIDTH_LOG-1:0] sel, pe_bin;
    logic                 pe_vld, acc, grant, xfer;

    logic                 out_vld_q, out_vld_d;
    logic                 out_lst_q, out_lst_d;
    DAT_T                 out_dat_q, out_dat_d;
    logic [WIDTH_LOG-1:0] out_idx_q, out_idx_d;
    DAT_T                 mux_dat;

    pri_rr_bin #(
        .WIDTH          (WIDTH),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_pri (
        .req (req_vld),
        .ptr (ptr_q),
        .bin (pe_bin),
        .vld (pe_vld)
    );

    mux_bin_tree #(
        .DAT_T          (DAT_T),
        .WIDTH          (WIDTH),
        .SPLIT          (SPLIT),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_mux (
        .in_dat  (req_dat),
        .bin     (sel),
        .out_dat (mux_dat)
    );

    // Pick the served requester and raise its ready when the output stage can take a beat.
    // While locked, ready stays on the held requester even if it has dropped valid.
    always_comb begin
        acc          = !out_vld_q || out_rdy;
        sel          = (state_q == LOCK) ? lck_q : pe_bin;
        grant        = acc && ((state_q == LOCK) || pe_vld);
        req_rdy      = '0;
        req_rdy[sel] = grant;
        xfer         = grant && req_vld[sel];
    end

    // Packet lock: a non-last beat pins the grant; the last beat releases it and moves ptr.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lck_d   = lck_q;
        if (xfer) begin
            case (state_q)
                IDLE: begin
                    if (req_lst[sel]) begin
                        ptr_d = sel;
                    end else begin
                        state_d = LOCK;
                        lck_d   = sel;
                    end
                end
                LOCK: begin
                    if (req_lst[sel]) begin
                        state_d = IDLE;
                        ptr_d   = lck_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output stage loads on transfer-in, empties on transfer-out; payload holds otherwise.
    always_comb begin
        out_vld_d = out_vld_q;
        out_lst_d = out_lst_q;
        out_dat_d = out_dat_q;
        out_idx_d = out_idx_q;
        if (xfer) begin
            out_vld_d = 1'b1;
            out_lst_d = req_lst[sel];
            out_dat_d = mux_dat;
            out_idx_d = sel;
        end else if (out_rdy) begin
            out_vld_d = 1'b0;
        end
    end

    // State registers; ptr resets to the top slot so requester 0 is considered first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '1;
            lck_q     <= '0;
            out_vld_q <= 1'b0;
            out_lst_q <= 1'b0;
            out_dat_q <= '0;
            out_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            lck_q     <= lck_d;
            out_vld_q <= out_vld_d;
            out_lst_q <= out_lst_d;
            out_dat_q <= out_dat_d;
            out_idx_q <= out_idx_d;
        end
    end

    assign out_vld = out_vld_q;
    assign out_lst = out_lst_q;
    assign out_dat = out_dat_q;
    assign out_idx = out_idx_q;

endmodule

// File: tb/tb_arb_rr_mux_bin.sv
// Bench for arb_rr_mux_bin: directed vector table on an 8-way radix-2 instance,
// hand-written reset-mid-packet sequence, and randomised scoreboard runs on
// 16-way radix-4 instances (both encoder/mux implementations).
module tb_arb_rr_mux_bin;

    logic clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    // ---------------- 8-way directed instance ----------------
    logic [7:0] d_vld, d_lst, d_rdy;
    logic [7:0] d_dat [8];
    logic       d_ovld, d_olst, d_ordy;
    logic [7:0] d_odat;
    logic [2:0] d_oidx;

    arb_rr_mux_bin #(
        .DAT_T          (logic [7:0]),
        .WIDTH          (8),
        .SPLIT          (2),
        .IMPLEMENTATION (0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_vld (d_vld),
        .req_lst (d_lst),
        .req_dat (d_dat),
        .req_rdy (d_rdy),
        .out_vld (d_ovld),
        .out_lst (d_olst),
        .out_dat (d_odat),
        .out_idx (d_oidx),
        .out_rdy (d_ordy)
    );

    // ---------------- 16-way random instances ----------------
    logic [15:0] r_vld, r_lst;
    logic [15:0] r_dat [16];
    logic        r_ordy;
    logic [15:0] r_rdy  [2];
    logic        r_ovld [2];
    logic        r_olst [2];
    logic [15:0] r_odat [2];
    logic [3:0]  r_oidx [2];
    int          cur;
    bit          lst_hist [16][4096];

    for (genvar gi = 0; gi < 2; gi++) begin : g_rnd
        arb_rr_mux_bin #(
            .DAT_T          (logic [15:0]),
            .WIDTH          (16),
            .SPLIT          (4),
            .IMPLEMENTATION (gi)
        ) dut_r (
            .clk     (clk),
            .rst_n   (rst_n),
            .req_vld (r_vld),
            .req_lst (r_lst),
            .req_dat (r_dat),
            .req_rdy (r_rdy[gi]),
            .out_vld (r_ovld[gi]),
            .out_lst (r_olst[gi]),
            .out_dat (r_odat[gi]),
            .out_idx (r_oidx[gi]),
            .out_rdy (r_ordy)
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One directed cycle: inputs, combinational ready, then registered outputs.
    typedef struct {
        logic [7:0] vld;
        logic [7:0] lst;
        logic       ordy;
        logic [7:0] exp_rdy;
        logic       exp_vld;
        logic       exp_lst;
        logic [2:0] exp_idx;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] vld, input logic [7:0] lst, input logic ordy,
                                input logic [7:0] exp_rdy, input logic exp_vld,
                                input logic exp_lst, input logic [2:0] exp_idx);
        vec_t v;
        v.vld = vld; v.lst = lst; v.ordy = ordy;
        v.exp_rdy = exp_rdy; v.exp_vld = exp_vld; v.exp_lst = exp_lst; v.exp_idx = exp_idx;
        return v;
    endfunction

    task automatic rand_phase(input int which, input int ncyc);
        logic [15:0] drop;
        int          seq_in  [16];
        int          seq_out [16];
        bit          mid     [16];
        bit          out_lock;
        int          lock_idx;
        int          n_in, n_out;
        bit          drain;
        logic [3:0]  idx;
        logic [15:0] exp_dat;
        bit          ok;

        cur    = which;
        r_vld  = '0;
        r_lst  = '0;
        r_ordy = 1'b0;
        for (int i = 0; i < 16; i++) r_dat[i] = '0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        drop = '0; out_lock = 1'b0; lock_idx = 0; n_in = 0; n_out = 0;
        for (int i = 0; i < 16; i++) begin
            seq_in[i] = 0; seq_out[i] = 0; mid[i] = 1'b0;
        end

        for (int c = 0; c < ncyc + 150; c++) begin
            drain = (c >= ncyc);
            for (int i = 0; i < 16; i++) begin
                if (drop[i]) r_vld[i] = 1'b0;
                if (!r_vld[i]) begin
                    if (drain ? mid[i] : ($urandom_range(0, 99) < 45)) begin
                        r_vld[i] = 1'b1;
                        r_dat[i] = {i[3:0], seq_in[i][11:0]};
                        r_lst[i] = drain ? 1'b1 : ($urandom_range(0, 2) == 0);
                    end
                end
            end
            r_ordy = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            chk("rdy_onehot", 32'($countones(r_rdy[cur]) <= 1), 32'd1);
            drop = r_vld & r_rdy[cur];
            for (int i = 0; i < 16; i++) begin
                if (drop[i]) begin
                    lst_hist[i][seq_in[i]] = r_lst[i];
                    mid[i] = !r_lst[i];
                    seq_in[i]++;
                    n_in++;
                end
            end
            if (r_ovld[cur] && r_ordy) begin
                idx     = r_oidx[cur];
                exp_dat = {idx, seq_out[idx][11:0]};
                ok = (seq_out[idx] < seq_in[idx]) && (r_odat[cur] == exp_dat) &&
                     (r_olst[cur] == lst_hist[idx][seq_out[idx]]) &&
                     (!out_lock || (32'(idx) == lock_idx));
                total++;
                if (!ok) begin
                    bad++;
                    $display("FAIL beat impl=%0d: got idx=%0d dat=%h lst=%0d required dat=%h lst=%0d lock=%0d/%0d",
                             which, idx, r_odat[cur], r_olst[cur], exp_dat,
                             lst_hist[idx][seq_out[idx]], out_lock, lock_idx);
                end
                $display("rand impl=%0d beat idx=%0d dat=%h lst=%0d", which, idx, r_odat[cur], r_olst[cur]);
                out_lock = !r_olst[cur];
                lock_idx = int'(idx);
                seq_out[idx]++;
                n_out++;
            end
            @(posedge clk); #1;
        end
        chk("beats_out_eq_in", 32'(n_out), 32'(n_in));
        chk("drained_out_vld", 32'(r_ovld[cur]), 32'd0);
    endtask

    vec_t tbl[$];

    initial begin
        rst_n  = 1'b0;
        d_vld  = '0;
        d_lst  = '0;
        d_ordy = 1'b1;
        for (int i = 0; i < 8; i++) d_dat[i] = 8'hA0 + 8'(i);
        r_vld  = '0;
        r_lst  = '0;
        r_ordy = 1'b0;
        cur    = 0;
        for (int i = 0; i < 16; i++) r_dat[i] = '0;

        // Full-rotation: requester 0 first, then 1..7, wrap to 0.
        for (int k = 0; k < 9; k++)
            tbl.push_back(mk(8'hFF, 8'hFF, 1'b1, 8'h01 << (k % 8), 1'b1, 1'b1, 3'(k % 8)));
        // Two requesters alternate, skipping 3 and 4.
        tbl.push_back(mk(8'h24, 8'hFF, 1'b1, 8'h04, 1'b1, 1'b1, 3'd2));
        tbl.push_back(mk(8'h24, 8'hFF, 1'b1, 8'h20, 1'b1, 1'b1, 3'd5));
        tbl.push_back(mk(8'h24, 8'hFF, 1'b1, 8'h04, 1'b1, 1'b1, 3'd2));
        tbl.push_back(mk(8'h24, 8'hFF, 1'b1, 8'h20, 1'b1, 1'b1, 3'd5));
        // Idle cycle: output drains, payload holds, ptr does not move.
        tbl.push_back(mk(8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1, 3'd5));
        // Requester 0 single beat (ptr -> 0), then 3-beat packet from 1 with a 2-cycle gap.
        tbl.push_back(mk(8'h01, 8'hFF, 1'b1, 8'h01, 1'b1, 1'b1, 3'd0));
        tbl.push_back(mk(8'h42, 8'h40, 1'b1, 8'h02, 1'b1, 1'b0, 3'd1));
        tbl.push_back(mk(8'h42, 8'h40, 1'b1, 8'h02, 1'b1, 1'b0, 3'd1));
        tbl.push_back(mk(8'h40, 8'h40, 1'b1, 8'h02, 1'b0, 1'b0, 3'd1));
        tbl.push_back(mk(8'h40, 8'h40, 1'b1, 8'h02, 1'b0, 1'b0, 3'd1));
        tbl.push_back(mk(8'h42, 8'h42, 1'b1, 8'h02, 1'b1, 1'b1, 3'd1));
        tbl.push_back(mk(8'h42, 8'h42, 1'b1, 8'h40, 1'b1, 1'b1, 3'd6));
        // Backpressure: 4 stalled cycles, then resume with 0 and 1.
        tbl.push_back(mk(8'hFF, 8'hFF, 1'b1, 8'h80, 1'b1, 1'b1, 3'd7));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b1, 3'd7));
        tbl.push_back(mk(8'hFF, 8'hFF, 1'b1, 8'h01, 1'b1, 1'b1, 3'd0));
        tbl.push_back(mk(8'hFF, 8'hFF, 1'b1, 8'h02, 1'b1, 1'b1, 3'd1));
        // Empty output stage accepts even with out_rdy low.
        tbl.push_back(mk(8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1, 3'd1));
        tbl.push_back(mk(8'h04, 8'hFF, 1'b0, 8'h04, 1'b1, 1'b1, 3'd2));
        tbl.push_back(mk(8'h00, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b1, 3'd2));
        tbl.push_back(mk(8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1, 3'd2));

        // Reset state.
        #12;
        chk("rst_out_vld", 32'(d_ovld), 32'd0);
        chk("rst_out_lst", 32'(d_olst), 32'd0);
        chk("rst_out_dat", 32'(d_odat), 32'd0);
        chk("rst_out_idx", 32'(d_oidx), 32'd0);
        chk("rst_req_rdy", 32'(d_rdy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[r]) begin
            d_vld  = tbl[r].vld;
            d_lst  = tbl[r].lst;
            d_ordy = tbl[r].ordy;
            #1;
            chk($sformatf("row%0d_req_rdy", r), 32'(d_rdy), 32'(tbl[r].exp_rdy));
            @(posedge clk); #1;
            chk($sformatf("row%0d_out_vld", r), 32'(d_ovld), 32'(tbl[r].exp_vld));
            chk($sformatf("row%0d_out_lst", r), 32'(d_olst), 32'(tbl[r].exp_lst));
            chk($sformatf("row%0d_out_idx", r), 32'(d_oidx), 32'(tbl[r].exp_idx));
            chk($sformatf("row%0d_out_dat", r), 32'(d_odat), 32'(8'hA0 | 8'(tbl[r].exp_idx)));
            $display("row %0d vld=%h lst=%h ordy=%0d rdy=%h out_vld=%0d idx=%0d dat=%h",
                     r, tbl[r].vld, tbl[r].lst, tbl[r].ordy, d_rdy, d_ovld, d_oidx, d_odat);
        end

        // Reset while requester 3 holds a lock; then 0 and 3 compete, 0 wins.
        d_vld = 8'h08; d_lst = 8'h00; d_ordy = 1'b1;
        #1;
        chk("lock_req_rdy", 32'(d_rdy), 32'h08);
        @(posedge clk); #1;
        chk("lock_out_idx", 32'(d_oidx), 32'd3);
        chk("lock_out_vld", 32'(d_ovld), 32'd1);
        rst_n = 1'b0;
        d_vld = 8'h09; d_lst = 8'hFF;
        #1;
        chk("async_rst_out_vld", 32'(d_ovld), 32'd0);
        chk("async_rst_out_idx", 32'(d_oidx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_req_rdy", 32'(d_rdy), 32'h01);
        @(posedge clk); #1;
        chk("post_rst_out_idx", 32'(d_oidx), 32'd0);
        chk("post_rst_out_vld", 32'(d_ovld), 32'd1);
        #1;
        chk("post_rst_req_rdy2", 32'(d_rdy), 32'h08);
        @(posedge clk); #1;
        chk("post_rst_out_idx2", 32'(d_oidx), 32'd3);
        chk("post_rst_out_dat2", 32'(d_odat), 32'hA3);
        $display("reset-mid-packet sequence idx=%0d dat=%h", d_oidx, d_odat);
        d_vld = 8'h00;

        // Randomised 16-way runs, one per implementation.
        rand_phase(0, 1500);
        rand_phase(1, 1500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
